video_layer_mixer: RTL and testbench



---
 rtl/video_layer_mixer.sv | 199 +++++++++++++++++++
 tb/tb_video_layer_mixer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/video_layer_mixer.sv
`default_nettype none
// ============================================================================
// Module  : video_layer_mixer
// Brief   : N-layer palette mixer with saturating sum, frame flash, sync delay
// Revision: 1.0
// ============================================================================
module video_layer_mixer #(
    parameter int  LAYERS = 4,
    parameter int  CW     = 4,
    localparam int AW     = $clog2(LAYERS) + 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_pix,
    input  logic [LAYERS-1:0] layer_in,
    input  logic              flash_in,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              hblank,
    input  logic              vblank,
    input  logic              color_mode,
    input  logic              pal_wr,
    input  logic [AW-1:0]     pal_addr,
    input  logic [3*CW-1:0]   pal_din,
    output logic [CW-1:0]     r,
    output logic [CW-1:0]     g,
    output logic [CW-1:0]     b,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              hblank_o,
    output logic              vblank_o,
    output logic              inv_o
);

    localparam int LW = AW - 1;
    localparam int SW = CW + $clog2(LAYERS + 1);
    localparam int NE = 2 * LAYERS;
    localparam logic [CW-1:0]   C_RST_COMP  = CW'((1 << (CW - 1)) - 1);
    localparam logic [3*CW-1:0] C_RST_ENTRY = {3{C_RST_COMP}};
    localparam logic [SW-1:0]   C_MAX       = SW'((1 << CW) - 1);

    logic [3*CW-1:0] pal_q [NE];
    logic [3*CW-1:0] pal_d [NE];
    logic [3*CW-1:0] s1_q  [LAYERS];
    logic [3*CW-1:0] s1_d  [LAYERS];

    logic hs1_q, vs1_q, hb1_q, vb1_q;
    logic hs1_d, vs1_d, hb1_d, vb1_d;
    logic [CW-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic hsync_o_q, vsync_o_q, hblank_o_q, vblank_o_q;
    logic hsync_o_d, vsync_o_d, hblank_o_d, vblank_o_d;
    logic old_vs_q, cur_inv_q, inv_q;
    logic old_vs_d, cur_inv_d, inv_d;
    logic [SW-1:0] sum_r, sum_g, sum_b;

    function automatic logic [CW-1:0] sat(input logic [SW-1:0] s);
        return (s > C_MAX) ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    // Palette writes ignore ce_pix; layer indices >= LAYERS never match a slot.
    always_comb begin
        pal_d = pal_q;
        if (pal_wr) begin
            for (int bk = 0; bk < 2; bk++) begin
                for (int i = 0; i < LAYERS; i++) begin
                    if (pal_addr == {1'(bk), LW'(i)}) begin
                        pal_d[bk*LAYERS + i] = pal_din;
                    end
                end
            end
        end
    end

    always_comb begin
        s1_d  = s1_q;
        hs1_d = hs1_q;
        vs1_d = vs1_q;
        hb1_d = hb1_q;
        vb1_d = vb1_q;
        if (ce_pix) begin
            for (int i = 0; i < LAYERS; i++) begin
                if (!layer_in[i]) begin
                    s1_d[i] = '0;
                end else if (color_mode) begin
                    s1_d[i] = pal_q[LAYERS + i];
                end else begin
                    s1_d[i] = pal_q[i];
                end
            end
            hs1_d = hsync;
            vs1_d = vsync;
            hb1_d = hblank;
            vb1_d = vblank;
        end
    end

    always_comb begin
        sum_r = '0;
        sum_g = '0;
        sum_b = '0;
        for (int i = 0; i < LAYERS; i++) begin
            sum_r = sum_r + SW'(s1_q[i][3*CW-1:2*CW]);
            sum_g = sum_g + SW'(s1_q[i][2*CW-1:CW]);
            sum_b = sum_b + SW'(s1_q[i][CW-1:0]);
        end
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        hsync_o_d  = hsync_o_q;
        vsync_o_d  = vsync_o_q;
        hblank_o_d = hblank_o_q;
        vblank_o_d = vblank_o_q;
        if (ce_pix) begin
            // Blanking wins over inversion so the border stays black during flash.
            if (hb1_q || vb1_q) begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end else begin
                r_d = sat(sum_r) ^ {CW{inv_q}};
                g_d = sat(sum_g) ^ {CW{inv_q}};
                b_d = sat(sum_b) ^ {CW{inv_q}};
            end
            hsync_o_d  = hs1_q;
            vsync_o_d  = vs1_q;
            hblank_o_d = hb1_q;
            vblank_o_d = vb1_q;
        end
    end

    // A request seen on the vsync edge tick still belongs to the ending frame.
    always_comb begin
        old_vs_d  = old_vs_q;
        cur_inv_d = cur_inv_q;
        inv_d     = inv_q;
        if (ce_pix) begin
            old_vs_d = vsync;
            if (vsync && !old_vs_q) begin
                inv_d     = cur_inv_q | flash_in;
                cur_inv_d = 1'b0;
            end else begin
                cur_inv_d = cur_inv_q | flash_in;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int k = 0; k < NE; k++) begin
                pal_q[k] <= C_RST_ENTRY;
            end
            for (int i = 0; i < LAYERS; i++) begin
                s1_q[i] <= '0;
            end
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            hb1_q      <= 1'b0;
            vb1_q      <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            hsync_o_q  <= 1'b0;
            vsync_o_q  <= 1'b0;
            hblank_o_q <= 1'b0;
            vblank_o_q <= 1'b0;
            old_vs_q   <= 1'b1;
            cur_inv_q  <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            pal_q      <= pal_d;
            s1_q       <= s1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            hb1_q      <= hb1_d;
            vb1_q      <= vb1_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            hsync_o_q  <= hsync_o_d;
            vsync_o_q  <= vsync_o_d;
            hblank_o_q <= hblank_o_d;
            vblank_o_q <= vblank_o_d;
            old_vs_q   <= old_vs_d;
            cur_inv_q  <= cur_inv_d;
            inv_q      <= inv_d;
        end
    end

    assign r        = r_q;
    assign g        = g_q;
    assign b        = b_q;
    assign hsync_o  = hsync_o_q;
    assign vsync_o  = vsync_o_q;
    assign hblank_o = hblank_o_q;
    assign vblank_o = vblank_o_q;
    assign inv_o    = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_video_layer_mixer.sv
`default_nettype none
// ============================================================================
// Module  : tb_video_layer_mixer
// Brief   : Directed self-checking bench for video_layer_mixer
// Revision: 1.0
// ============================================================================
module tb_video_layer_mixer;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic        reset, ce_pix, flash_in, hsync, vsync, hblank, vblank;
    logic        color_mode, pal_wr;
    logic [3:0]  layer_in;
    logic [2:0]  pal_addr;
    logic [11:0] pal_din;
    logic [3:0]  r, g, b;
    logic        hsync_o, vsync_o, hblank_o, vblank_o, inv_o;

    logic        pal_wr5;
    logic [4:0]  layer5;
    logic [3:0]  pal_addr5;
    logic [3:0]  r5, g5, b5;
    logic        hs5, vs5, hb5, vb5, inv5;

    int nvec = 0;
    int nerr = 0;

    video_layer_mixer #(.LAYERS(4), .CW(4)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .layer_in(layer_in),
        .flash_in(flash_in), .hsync(hsync), .vsync(vsync), .hblank(hblank),
        .vblank(vblank), .color_mode(color_mode), .pal_wr(pal_wr),
        .pal_addr(pal_addr), .pal_din(pal_din), .r(r), .g(g), .b(b),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .hblank_o(hblank_o),
        .vblank_o(vblank_o), .inv_o(inv_o)
    );

    video_layer_mixer #(.LAYERS(5), .CW(4)) dut5 (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .layer_in(layer5),
        .flash_in(flash_in), .hsync(hsync), .vsync(vsync), .hblank(hblank),
        .vblank(vblank), .color_mode(color_mode), .pal_wr(pal_wr5),
        .pal_addr(pal_addr5), .pal_din(pal_din), .r(r5), .g(g5), .b(b5),
        .hsync_o(hs5), .vsync_o(vs5), .hblank_o(hb5),
        .vblank_o(vb5), .inv_o(inv5)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ce_pix = 1'b1; flash_in = 1'b0; hsync = 1'b0; vsync = 1'b1;
        hblank = 1'b0; vblank = 1'b0; color_mode = 1'b0; pal_wr = 1'b0;
        layer_in = '0; pal_addr = '0; pal_din = '0;
        pal_wr5 = 1'b0; layer5 = '0; pal_addr5 = '0;

        // Reset with vsync held high, then release
        tick(3);
        chk("rst_rgb", {r, g, b}, 12'h000);
        chk("rst_inv", inv_o, 1'b0);
        chk("rst_vsync_o", vsync_o, 1'b0);
        reset = 1'b0;
        tick(1);
        chk("rel_rgb", {r, g, b}, 12'h000);
        chk("rel_inv", inv_o, 1'b0);
        tick(3);
        chk("rel_inv_hold", inv_o, 1'b0);
        vsync = 1'b0;
        tick(2);
        chk("rel_inv_vs_low", inv_o, 1'b0);

        // Single layer: two-tick latency, freeze with ce_pix low
        layer_in = 4'b0001;
        tick(1);
        chk("lat_tick1", {r, g, b}, 12'h000);
        tick(1);
        chk("lat_tick2", {r, g, b}, 12'h777);
        ce_pix = 1'b0; layer_in = 4'b0000;
        tick(3);
        chk("ce_hold", {r, g, b}, 12'h777);
        ce_pix = 1'b1;
        tick(1);
        chk("ce_resume1", {r, g, b}, 12'h777);
        tick(1);
        chk("ce_resume2", {r, g, b}, 12'h000);

        // Bank switch
        pal_wr = 1'b1; pal_addr = 3'b110; pal_din = 12'h0FF;
        tick(1);
        pal_wr = 1'b0;
        layer_in = 4'b0100; color_mode = 1'b0;
        tick(2);
        chk("bank0_l2", {r, g, b}, 12'h777);
        color_mode = 1'b1;
        tick(1);
        chk("bank_sw_t1", {r, g, b}, 12'h777);
        tick(1);
        chk("bank_sw_t2", {r, g, b}, 12'h0FF);

        // Saturation
        color_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pal_wr = 1'b1; pal_addr = 3'(i); pal_din = 12'h930;
            tick(1);
        end
        pal_wr = 1'b0;
        layer_in = 4'b0001;
        tick(2);
        chk("one_layer", {r, g, b}, 12'h930);
        layer_in = 4'b1111;
        tick(2);
        chk("sat_all", {r, g, b}, 12'hFC0);
        layer_in = 4'b0011;
        tick(2);
        chk("sat_two", {r, g, b}, 12'hF60);

        // Flash latch: bank 1 layer 0 still holds the reset 0x777
        color_mode = 1'b1; layer_in = 4'b0001;
        tick(2);
        chk("flash_base", {r, g, b}, 12'h777);
        vsync = 1'b1; tick(1); vsync = 1'b0;
        tick(3);
        chk("F_inv", inv_o, 1'b0);
        flash_in = 1'b1; tick(1); flash_in = 1'b0;
        tick(3);
        chk("F_pending_inv", inv_o, 1'b0);
        chk("F_pix", {r, g, b}, 12'h777);
        vsync = 1'b1; tick(1); vsync = 1'b0;
        chk("E1_inv", inv_o, 1'b1);
        chk("E1_pix", {r, g, b}, 12'h777);
        tick(1);
        chk("F1_pix", {r, g, b}, 12'h888);
        tick(3);
        chk("F1_inv", inv_o, 1'b1);
        hblank = 1'b1;
        tick(1);
        chk("blank_t1", {r, g, b}, 12'h888);
        tick(1);
        chk("blank_t2", {r, g, b}, 12'h000);
        chk("hblank_o", hblank_o, 1'b1);
        hblank = 1'b0;
        tick(2);
        chk("unblank", {r, g, b}, 12'h888);
        vsync = 1'b1; flash_in = 1'b1; tick(1); vsync = 1'b0; flash_in = 1'b0;
        chk("E2_inv", inv_o, 1'b1);
        tick(1);
        chk("vsync_o_rise", vsync_o, 1'b1);
        tick(1);
        chk("vsync_o_fall", vsync_o, 1'b0);
        chk("F2_pix", {r, g, b}, 12'h888);
        chk("F2_inv", inv_o, 1'b1);
        vsync = 1'b1; tick(1); vsync = 1'b0;
        chk("E3_inv", inv_o, 1'b0);
        tick(1);
        chk("F3_pix", {r, g, b}, 12'h777);

        // Reset mid-frame with pending flash; write during reset is ignored
        tick(3);
        flash_in = 1'b1; tick(1); flash_in = 1'b0;
        tick(2);
        reset = 1'b1; pal_wr = 1'b1; pal_addr = 3'b000; pal_din = 12'h000;
        tick(2);
        chk("midrst_rgb", {r, g, b}, 12'h000);
        reset = 1'b0; pal_wr = 1'b0;
        tick(3);
        vsync = 1'b1; tick(1); vsync = 1'b0;
        chk("postrst_inv_e1", inv_o, 1'b0);
        tick(4);
        vsync = 1'b1; tick(1); vsync = 1'b0;
        chk("postrst_inv_e2", inv_o, 1'b0);
        color_mode = 1'b0; layer_in = 4'b0001;
        tick(2);
        chk("postrst_pal", {r, g, b}, 12'h777);

        // Out-of-range layer writes on a five-layer instance
        pal_din = 12'h000; pal_wr5 = 1'b1;
        pal_addr5 = 4'b0101; tick(1);
        pal_addr5 = 4'b1101; tick(1);
        pal_addr5 = 4'b0111; tick(1);
        pal_addr5 = 4'b0100; pal_din = 12'h123; tick(1);
        pal_wr5 = 1'b0;
        for (int bk = 0; bk < 2; bk++) begin
            for (int i = 0; i < 5; i++) begin
                color_mode = bk[0];
                layer5 = 5'(1 << i);
                tick(2);
                chk($sformatf("oor_b%0d_l%0d", bk, i), {r5, g5, b5},
                    (bk == 0 && i == 4) ? 12'h123 : 12'h777);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
